// File: rtl/codec_init_sequencer_pkg.sv
// Shared constants for the WM8731 codec init sequencer: bus register map,
// FSM state encoding and WM8731 I2C packet helpers.
package codec_init_sequencer_pkg;

  localparam logic [2:0] ADDR_I2C_DATA_AUDIO = 3'd1;
  localparam logic [2:0] ADDR_DAC_AUDIO      = 3'd2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_REQ   = 3'd1;
  localparam logic [2:0] ST_WR_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT_IRQ = 3'd3;
  localparam logic [2:0] ST_NEXT     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;

  localparam logic [7:0]  WM8731_DEV_ADDR = 8'h34;
  localparam logic [23:0] PKT_RESET       = 24'h341E00;
  localparam logic [23:0] PKT_POWER_ON    = 24'h340C00;
  localparam logic [23:0] PKT_ACTIVATE    = 24'h341201;

  // WM8731 packs a 7-bit register number above a 9-bit value.
  function automatic logic [23:0] wm8731_pkt(input logic [6:0] reg_num,
                                             input logic [8:0] val);
    return {WM8731_DEV_ADDR, reg_num, val};
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Packet table for the codec init run: index -> 24-bit I2C packet.
// The last used index always returns the activate packet.
module codec_init_rom
  import codec_init_sequencer_pkg::*;
#(
  parameter int INIT_LEN = 10,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0] index_i,
  output logic [23:0]      packet_o
);

  logic [31:0] idx32;
  assign idx32 = 32'(index_i);

  always_comb begin
    packet_o = PKT_ACTIVATE;
    if (idx32 != 32'(INIT_LEN - 1)) begin
      case (idx32)
        32'd0:   packet_o = PKT_RESET;
        32'd1:   packet_o = PKT_POWER_ON;
        32'd2:   packet_o = wm8731_pkt(7'h00, 9'h017);
        32'd3:   packet_o = wm8731_pkt(7'h01, 9'h017);
        32'd4:   packet_o = wm8731_pkt(7'h02, 9'h079);
        32'd5:   packet_o = wm8731_pkt(7'h03, 9'h079);
        32'd6:   packet_o = wm8731_pkt(7'h04, 9'h012);
        32'd7:   packet_o = wm8731_pkt(7'h05, 9'h000);
        32'd8:   packet_o = wm8731_pkt(7'h07, 9'h001);
        32'd9:   packet_o = wm8731_pkt(7'h08, 9'h000);
        default: packet_o = PKT_ACTIVATE;
      endcase
    end
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Codec init sequencer: read-modify-writes INIT_LEN WM8731 packets into the
// I2C data register, waiting for master_irq after each. Timeout option: CODEC_INIT_TIMEOUT_EN.
module codec_init_sequencer
  import codec_init_sequencer_pkg::*;
#(
  parameter int INIT_LEN       = 10,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        master_read,
  output logic        master_write,
  output logic        master_chipselect,
  output logic [2:0]  master_address,
  output logic [31:0] master_writedata,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest,
  input  logic        master_irq
);

  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             rd_q, rd_d, wr_q, wr_d, cs_q, cs_d;
  logic [2:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [7:0]       capt_q, capt_d;
  logic [23:0]      pkt;
  logic             unused_rd;

  assign unused_rd = ^master_readdata[23:0];

  codec_init_rom #(.INIT_LEN(INIT_LEN), .IDX_W(IDX_W)) u_rom (
    .index_i  (index_q),
    .packet_o (pkt)
  );

`ifdef CODEC_INIT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    capt_d  = capt_q;
`ifdef CODEC_INIT_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RD_REQ;
        index_d = '0;
        rd_d    = 1'b1;
        cs_d    = 1'b1;
        addr_d  = ADDR_I2C_DATA_AUDIO;
`ifdef CODEC_INIT_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      ST_RD_REQ: if (rd_q && !master_waitrequest) begin
        capt_d  = master_readdata[31:24];
        rd_d    = 1'b0;
        cs_d    = 1'b0;
        state_d = ST_WR_REQ;
      end
      // First WR_REQ cycle is the mandatory idle gap after the read.
      ST_WR_REQ: if (!wr_q) begin
        wr_d    = 1'b1;
        cs_d    = 1'b1;
        addr_d  = ADDR_I2C_DATA_AUDIO;
        wdata_d = {capt_q, pkt};
      end else if (!master_waitrequest) begin
        wr_d    = 1'b0;
        cs_d    = 1'b0;
        state_d = ST_WAIT_IRQ;
`ifdef CODEC_INIT_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT_IRQ: if (master_irq) begin
        state_d = ST_NEXT;
`ifdef CODEC_INIT_TIMEOUT_EN
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end else begin
        tmo_d   = tmo_q + 1'b1;
`endif
      end
      ST_NEXT: if (index_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        index_d = index_q + 1'b1;
        rd_d    = 1'b1;
        cs_d    = 1'b1;
        addr_d  = ADDR_I2C_DATA_AUDIO;
        state_d = ST_RD_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      capt_q  <= '0;
`ifdef CODEC_INIT_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      capt_q  <= capt_d;
`ifdef CODEC_INIT_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy              = !Reset && ((state_q != ST_IDLE) || start);
  assign done              = (state_q == ST_DONE);
  assign master_read       = rd_q;
  assign master_write      = wr_q;
  assign master_chipselect = cs_q;
  assign master_address    = addr_q;
  assign master_writedata  = wdata_q;

endmodule

// File: doc/codec_init_sequencer.md
CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

Interface
REQ-001 SHALL have parameter INIT_LEN, default 10, number of I2C packets sent per init run (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum Clk cycles spent waiting for master_irq per packet.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on posedge Clk.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that launches an init run.
REQ-006 SHALL have port busy  output  1  high while a run is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the last packet is acknowledged.
REQ-008 SHALL have port error  output  1  sticky; set on timeout; cleared by the next accepted start or by Reset.
REQ-009 SHALL have ports master_read, master_write, master_chipselect  output  1 each  bus request strobes, active high.
REQ-010 SHALL have port master_address  output  3  register address.
REQ-011 SHALL have ports master_writedata  output  32  and master_readdata  input  32  write and read buses.
REQ-012 SHALL have ports master_waitrequest  input  1  and master_irq  input  1  slave stall and I2C-complete interrupt.

Function
REQ-013 SHALL implement states IDLE, RD_REQ, WR_REQ, WAIT_IRQ, NEXT, DONE, ERROR.
REQ-014 SHALL, in IDLE, accept start: clear error, set index to 0 and go to RD_REQ on the next edge; busy rises in the same cycle.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 SHALL, in RD_REQ, drive master_read=1, master_chipselect=1 and master_address=ADDR_I2C_DATA_AUDIO.
REQ-017 SHALL hold all request outputs stable while master_waitrequest=1.
REQ-018 SHALL treat a transfer as complete on the first edge with the request high and master_waitrequest=0; master_readdata is captured on that edge.
REQ-019 SHALL, in WR_REQ, write {captured[31:24], packet[index][23:0]} to ADDR_I2C_DATA_AUDIO (read-modify-write preserving bits 31:24), using master_write and master_chipselect.
REQ-020 SHALL drive all strobes low in the cycle after each transfer completes; there are no back-to-back requests.
REQ-021 SHALL, in WAIT_IRQ, go to NEXT on master_irq=1; master_irq SHALL be sampled only in WAIT_IRQ.
REQ-022 SHALL, in NEXT, increment index and go to RD_REQ, or go to DONE when index = INIT_LEN-1; the index never wraps.
REQ-023 SHALL, in DONE, pulse done for one cycle and return to IDLE with busy=0.
REQ-024 SHALL size the index counter to clog2(INIT_LEN) bits and the timeout counter to clog2(TIMEOUT_CYCLES+1) bits.

Reset
REQ-025 SHALL, on Reset, go to IDLE and drive every output low, master_address=0, master_writedata=0, index=0 and counters=0.
REQ-026 SHALL, on Reset asserted mid-transfer, drop the strobes at that edge regardless of master_waitrequest.
REQ-027 SHALL give Reset priority over start when both are high on the same edge.

Configuration
REQ-028 SHALL, with CODEC_INIT_TIMEOUT_EN defined: count cycles in WAIT_IRQ; when the count reaches TIMEOUT_CYCLES without master_irq, go to ERROR, set error, pulse nothing on done and return to IDLE the next cycle.
REQ-029 SHALL, without CODEC_INIT_TIMEOUT_EN: omit the counter, never enter ERROR, keep error tied 0, and wait in WAIT_IRQ indefinitely.

Structure
REQ-030 SHALL source ADDR_I2C_DATA_AUDIO and ADDR_DAC_AUDIO from the shared global include; the state encoding and WM8731 packet constants (device address 8'h34) belong in the shared package.
REQ-031 SHALL place the packet table in sub-module codec_init_rom: combinational index -> 24-bit packet, with entry 0 = 24'h341E00 (codec reset), entry 1 = 24'h340C00 (power on) and the last entry = 24'h341201 (activate).

Verification
REQ-032 SHALL cover a nominal run: start; slave returns readdata=32'hA5000000 with zero wait; irq 5 cycles after each write -> 10 writes, the first 32'hA5341E00, one done pulse, error=0.
REQ-033 SHALL cover wait states: waitrequest held 3 cycles on read and 2 on write -> strobes and address stable during the stall, each transfer completes exactly once.
REQ-034 SHALL cover a timeout (macro on, TIMEOUT_CYCLES=100): irq never asserts after packet 0 -> error=1 at cycle 100 of WAIT_IRQ, busy falls, done stays 0.
REQ-035 SHALL cover spurious irq and start: irq pulsed during RD_REQ and start pulsed mid-run -> both ignored, sequence unchanged.
REQ-036 SHALL cover reset mid-write: Reset asserted while write+waitrequest=1 -> all strobes 0 at the next edge; a subsequent start restarts at index 0.
